sal_multi_bk_ctrl: RTL
======================

Name: sal_multi_bk_ctrl

Overview:
Parametrised multi-bank DRAM bank controller for the SAL memory controller. It holds NUM_BK independent per-bank state machines and tracks ACT/RD/WR/PRE/REF timing for each bank. Compared with a single-bank controller it adds per-bank refresh sequencing, a selectable page policy and a single arbitrated command output. It sits between the address decoder (request side) and the DDR command scheduler (command side).

Parameters:
NUM_BK, 4, number of banks; at least 1.
BA_W, 2, bank address width; equals clog2(NUM_BK), minimum 1.
RA_W, 16, row address width.
CA_W, 10, column address width.
ID_W, 4, request ID width.
LEN_W, 4, burst length field width.
TW, 8, width of every timing input and internal counter.
BURST_LEN, 8, data beats per burst; column-to-column spacing is BURST_LEN/2 cycles.
OPEN_PAGE, 1, 1 = open-page policy, 0 = close-page (auto-precharge) policy.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
t_rcd, t_ras, t_rc, t_rp, t_rtp, t_wtp, t_rfc, row_open_cnt  in  TW each  timing values in cycles; quasi-static
req_valid  in  1  request pending
req_ready  out  1  request consumed this cycle
req_wr  in  1  1 = write, 0 = read
req_ba  in  BA_W  request bank
req_ra  in  RA_W  request row
req_ca  in  CA_W  request column
req_id  in  ID_W  request ID
req_len  in  LEN_W  request burst length
cmd_valid  out  1  command issued this cycle
cmd_ready  in  1  scheduler accepts the command
cmd_type  out  3  NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5
cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len  out  BA_W/RA_W/CA_W/ID_W/LEN_W  command fields
ref_req_i  in  NUM_BK  per-bank refresh request (level)
ref_gnt_o  out  NUM_BK  one-cycle pulse when that bank's REF is issued
bank_open_o  out  NUM_BK  bank has an open row

Behaviour:
- Reset: all banks go to IDLE, all counters clear to 0, all outputs 0, and cmd_type=NOP. Reset asserted mid-operation aborts any sequence immediately with no command issued.
- A command is "issued" when cmd_valid & cmd_ready. All state and counter updates happen only on issue. cmd_valid may drop without being issued; nothing then changes.
- Per-bank states: IDLE, ACTIVATING, ACTIVE, READING, WRITING, PRECHARGING, REFRESHING.
- Timing, for a command issued at cycle t:
  - ACT: RD/WR allowed from t+t_rcd; PRE from t+t_ras; next ACT from t+t_rc.
  - RD: PRE allowed from t+t_rtp.
  - WR: PRE allowed from t+t_wtp.
  - RD/WR: next RD/WR allowed from t+BURST_LEN/2.
  - PRE: ACT/REF allowed from t+t_rp.
  - REF: ACT allowed from t+t_rfc.
  - A timing value of 0 is treated as 1. Counters saturate at 0 and never wrap.
- State transitions:
  - IDLE -> ACTIVATING on ACT.
  - ACTIVATING -> ACTIVE when tRCD expires.
  - ACTIVE -> READING/WRITING on RD/WR, and back to ACTIVE after BURST_LEN/2 cycles.
  - ACTIVE -> PRECHARGING on PRE.
  - PRECHARGING -> IDLE when tRP expires.
  - IDLE -> REFRESHING on REF.
  - REFRESHING -> IDLE when tRFC expires.
- Request path (bank req_ba only):
  - IDLE: issue ACT with req_ra.
  - ACTIVE with row hit: issue RD/WR. req_ready=1 in the same cycle as issue, never otherwise.
  - ACTIVE with row miss: issue PRE.
- Open page (OPEN_PAGE=1): an idle-row counter loads row_open_cnt on each ACT/RD/WR. At zero, the bank self-precharges once tRAS/tRTP/tWTP are met.
- Close page (OPEN_PAGE=0): after RD/WR the bank issues PRE as soon as timing allows, unless a row-hit request to that bank is valid that cycle.
- Refresh, bank b with ref_req_i[b]=1:
  - New ACT to b is blocked.
  - If b is active, new RD/WR to b is blocked and PRE is issued when timing allows.
  - REF is issued from IDLE once tRP/tRC are met. ref_gnt_o[b] pulses in the REF issue cycle.
- Arbitration, one command per cycle, fixed priority:
  1. REF
  2. refresh- or policy-driven PRE
  3. request-path command
  Ties go to the lowest bank index.
- Simultaneous refresh-PRE and row-hit to the same bank: PRE wins and req_ready stays 0.
- cmd_* fields are don't-care (driven 0) when cmd_valid=0.

Decomposition:
- Package sal_bk_pkg holds cmd_type_t (enum), bk_state_t (enum) and timing-struct typedefs.
- Sub-module sal_bk_fsm: one bank's FSM plus its timing counters. It outputs per-bank command candidates and takes a grant back. Instantiate it NUM_BK times in a generate loop. The top level holds the arbiter and the output mux.

Test Plan:
- Timing t_rcd=4, t_ras=16, t_rc=22, t_rp=4; read bank 0 row 5 with cmd_ready=1 -> ACT at cycle 0, RD at cycle 4 with req_ready=1, bank_open_o=4'b0001.
- Bank 0 row 5 open, read to row 9 at cycle 5 -> PRE no earlier than cycle 16 (tRAS), ACT row 9 no earlier than cycle 22.
- ref_req_i=4'b0011 with all banks idle -> REF bank 0, then REF bank 1 in the next cycle, each with ref_gnt_o pulsed; an ACT to bank 1 is blocked for t_rfc=10 cycles after its REF.
- OPEN_PAGE=0, WR at cycle t with t_wtp=8 and no further requests -> PRE issued at t+8.
- OPEN_PAGE=1, row_open_cnt=31, row left idle -> self PRE 31 cycles after the last access.
- Hold cmd_ready=0 for 3 cycles with a pending ACT -> no state change and cmd_valid held; assert rst mid-READING -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/sal_bk_pkg.sv
// sal_bk_pkg: command/state encodings, timing bundle and counter helpers
// shared by the SAL multi-bank controller and its per-bank FSMs.
package sal_bk_pkg;
    localparam int SAL_TW = 8;

    typedef logic [SAL_TW-1:0] tw_t;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_type_t;

    typedef enum logic [2:0] {
        BK_IDLE,
        BK_ACTIVATING,
        BK_ACTIVE,
        BK_READING,
        BK_WRITING,
        BK_PRECHARGING,
        BK_REFRESHING
    } bk_state_t;

    typedef struct packed {
        tw_t rcd;
        tw_t ras;
        tw_t rc;
        tw_t rp;
        tw_t rtp;
        tw_t wtp;
        tw_t rfc;
        tw_t roc;
    } tim_t;

    // A counter loaded with v-1 reaches 0 exactly v cycles after the command; 0 acts as 1.
    function automatic tw_t tim_ld(input tw_t v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    function automatic tw_t tim_dec(input tw_t c);
        return (c == '0) ? '0 : c - 1'b1;
    endfunction
endpackage

// File: rtl/sal_bk_fsm.sv
// sal_bk_fsm: one DRAM bank's state machine and timing counters; raises
// REF / priority-PRE / request-path candidates and updates when granted.
module sal_bk_fsm
    import sal_bk_pkg::*;
#(
    parameter int RA_W      = 16,
    parameter int BURST_LEN = 8,
    parameter int OPEN_PAGE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  tim_t            tim,
    input  logic            req_v,
    input  logic            req_wr,
    input  logic [RA_W-1:0] req_ra,
    input  logic            ref_req,
    input  logic            iss,
    input  cmd_type_t       iss_cmd,
    output logic            ref_c,
    output logic            pre_c,
    output logic            req_c,
    output cmd_type_t       req_cmd,
    output logic            open_o
);
    localparam tw_t CCD_LD = tw_t'((BURST_LEN / 2 > 1) ? BURST_LEN / 2 - 1 : 0);

    bk_state_t       state_q, state_d, eff;
    logic [RA_W-1:0] row_q, row_d;
    tw_t             rcd_q, rcd_d, ras_q, ras_d, rc_q, rc_d, rp_q, rp_d;
    tw_t             c2p_q, c2p_d, ccd_q, ccd_d, rfc_q, rfc_d, idle_q, idle_d;
    logic            ap_q, ap_d;
    logic            hit, act_ok, col_ok, pre_ok, expired;

    // eff folds in transitions whose timer has already run out, so a command can
    // issue in the very cycle its wait ends rather than one cycle later.
    always_comb begin
        eff = ((state_q == BK_ACTIVATING && rcd_q == '0) ||
               ((state_q == BK_READING || state_q == BK_WRITING) && ccd_q == '0)) ? BK_ACTIVE :
              ((state_q == BK_PRECHARGING && rp_q == '0) ||
               (state_q == BK_REFRESHING && rfc_q == '0)) ? BK_IDLE : state_q;
    end

    assign hit     = req_v && (row_q == req_ra);
    assign act_ok  = (eff == BK_IDLE) && (rc_q == '0) && (rp_q == '0) && (rfc_q == '0);
    assign col_ok  = (eff == BK_ACTIVE) && !ref_req;
    assign pre_ok  = (eff == BK_ACTIVE) && (ras_q == '0) && (c2p_q == '0);
    assign expired = (OPEN_PAGE != 0) ? (idle_q == '0) : (ap_q && !hit);

    assign ref_c   = ref_req && act_ok;
    assign pre_c   = pre_ok && (ref_req || expired);
    assign req_cmd = (eff == BK_IDLE) ? CMD_ACT : hit ? (req_wr ? CMD_WR : CMD_RD) : CMD_PRE;
    assign req_c   = req_v && ((eff == BK_IDLE) ? (act_ok && !ref_req) : hit ? col_ok : pre_ok);
    assign open_o  = (state_q == BK_ACTIVATING) || (state_q == BK_ACTIVE) ||
                     (state_q == BK_READING) || (state_q == BK_WRITING);

    always_comb begin
        state_d = eff;
        row_d   = row_q;
        rcd_d   = tim_dec(rcd_q);
        ras_d   = tim_dec(ras_q);
        rc_d    = tim_dec(rc_q);
        rp_d    = tim_dec(rp_q);
        c2p_d   = tim_dec(c2p_q);
        ccd_d   = tim_dec(ccd_q);
        rfc_d   = tim_dec(rfc_q);
        idle_d  = tim_dec(idle_q);
        ap_d    = ap_q;
        if (iss) begin
            case (iss_cmd)
                CMD_ACT: begin
                    state_d = BK_ACTIVATING;
                    row_d   = req_ra;
                    rcd_d   = tim_ld(tim.rcd);
                    ras_d   = tim_ld(tim.ras);
                    rc_d    = tim_ld(tim.rc);
                    idle_d  = tim_ld(tim.roc);
                    ap_d    = 1'b0;
                end
                CMD_RD, CMD_WR: begin
                    state_d = (iss_cmd == CMD_WR) ? BK_WRITING : BK_READING;
                    c2p_d   = tim_ld((iss_cmd == CMD_WR) ? tim.wtp : tim.rtp);
                    ccd_d   = CCD_LD;
                    idle_d  = tim_ld(tim.roc);
                    ap_d    = 1'b1;
                end
                CMD_PRE: begin
                    state_d = BK_PRECHARGING;
                    rp_d    = tim_ld(tim.rp);
                    ap_d    = 1'b0;
                end
                CMD_REF: begin
                    state_d = BK_REFRESHING;
                    rfc_d   = tim_ld(tim.rfc);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BK_IDLE;
            row_q   <= '0;
            rcd_q   <= '0;
            ras_q   <= '0;
            rc_q    <= '0;
            rp_q    <= '0;
            c2p_q   <= '0;
            ccd_q   <= '0;
            rfc_q   <= '0;
            idle_q  <= '0;
            ap_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            rcd_q   <= rcd_d;
            ras_q   <= ras_d;
            rc_q    <= rc_d;
            rp_q    <= rp_d;
            c2p_q   <= c2p_d;
            ccd_q   <= ccd_d;
            rfc_q   <= rfc_d;
            idle_q  <= idle_d;
            ap_q    <= ap_d;
        end
    end
endmodule

// File: rtl/sal_multi_bk_ctrl.sv
// sal_multi_bk_ctrl: NUM_BK bank FSMs behind a fixed-priority single-command
// arbiter (REF, then refresh/policy PRE, then request path; lowest bank first).
module sal_multi_bk_ctrl
    import sal_bk_pkg::*;
#(
    parameter int NUM_BK    = 4,
    parameter int BA_W      = 2,
    parameter int RA_W      = 16,
    parameter int CA_W      = 10,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 4,
    parameter int TW        = SAL_TW,
    parameter int BURST_LEN = 8,
    parameter int OPEN_PAGE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TW-1:0]     t_rcd,
    input  logic [TW-1:0]     t_ras,
    input  logic [TW-1:0]     t_rc,
    input  logic [TW-1:0]     t_rp,
    input  logic [TW-1:0]     t_rtp,
    input  logic [TW-1:0]     t_wtp,
    input  logic [TW-1:0]     t_rfc,
    input  logic [TW-1:0]     row_open_cnt,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [BA_W-1:0]   req_ba,
    input  logic [RA_W-1:0]   req_ra,
    input  logic [CA_W-1:0]   req_ca,
    input  logic [ID_W-1:0]   req_id,
    input  logic [LEN_W-1:0]  req_len,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [2:0]        cmd_type,
    output logic [BA_W-1:0]   cmd_ba,
    output logic [RA_W-1:0]   cmd_ra,
    output logic [CA_W-1:0]   cmd_ca,
    output logic [ID_W-1:0]   cmd_id,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic [NUM_BK-1:0] ref_req_i,
    output logic [NUM_BK-1:0] ref_gnt_o,
    output logic [NUM_BK-1:0] bank_open_o
);
    tim_t              tim;
    logic [NUM_BK-1:0] ref_c, pre_c, req_c, iss;
    cmd_type_t         req_cmd [NUM_BK];
    logic              sel_v, sel_req, issue, fld, col;
    logic [BA_W-1:0]   sel_bk;
    cmd_type_t         sel_t;

    assign tim = '{rcd: tw_t'(t_rcd), ras: tw_t'(t_ras), rc: tw_t'(t_rc), rp: tw_t'(t_rp),
                   rtp: tw_t'(t_rtp), wtp: tw_t'(t_wtp), rfc: tw_t'(t_rfc), roc: tw_t'(row_open_cnt)};

    for (genvar b = 0; b < NUM_BK; b++) begin : g_bk
        assign iss[b] = issue && (sel_bk == BA_W'(b));
        sal_bk_fsm #(
            .RA_W     (RA_W),
            .BURST_LEN(BURST_LEN),
            .OPEN_PAGE(OPEN_PAGE)
        ) u_fsm (
            .clk    (clk),
            .rst    (rst),
            .tim    (tim),
            .req_v  (req_valid && (req_ba == BA_W'(b))),
            .req_wr (req_wr),
            .req_ra (req_ra),
            .ref_req(ref_req_i[b]),
            .iss    (iss[b]),
            .iss_cmd(sel_t),
            .ref_c  (ref_c[b]),
            .pre_c  (pre_c[b]),
            .req_c  (req_c[b]),
            .req_cmd(req_cmd[b]),
            .open_o (bank_open_o[b])
        );
    end

    // Lower-priority classes are scanned first so later, higher-priority hits
    // overwrite them; descending scans leave the lowest bank as the winner.
    always_comb begin
        sel_v   = 1'b0;
        sel_req = 1'b0;
        sel_bk  = '0;
        sel_t   = CMD_NOP;
        for (int i = NUM_BK - 1; i >= 0; i--) begin
            if (req_c[i]) begin
                sel_v   = 1'b1;
                sel_req = 1'b1;
                sel_bk  = BA_W'(i);
                sel_t   = req_cmd[i];
            end
        end
        for (int i = NUM_BK - 1; i >= 0; i--) begin
            if (pre_c[i]) begin
                sel_v   = 1'b1;
                sel_req = 1'b0;
                sel_bk  = BA_W'(i);
                sel_t   = CMD_PRE;
            end
        end
        for (int i = NUM_BK - 1; i >= 0; i--) begin
            if (ref_c[i]) begin
                sel_v   = 1'b1;
                sel_req = 1'b0;
                sel_bk  = BA_W'(i);
                sel_t   = CMD_REF;
            end
        end
    end

    assign cmd_valid = sel_v && !rst;
    assign issue     = cmd_valid && cmd_ready;
    assign fld       = cmd_valid && sel_req && (sel_t != CMD_PRE);
    assign col       = fld && (sel_t != CMD_ACT);
    assign cmd_type  = cmd_valid ? sel_t : CMD_NOP;
    assign cmd_ba    = cmd_valid ? sel_bk : '0;
    assign cmd_ra    = fld ? req_ra : '0;
    assign cmd_ca    = col ? req_ca : '0;
    assign cmd_id    = col ? req_id : '0;
    assign cmd_len   = col ? req_len : '0;
    assign req_ready = issue && col;
    assign ref_gnt_o = (sel_t == CMD_REF) ? iss : '0;
endmodule
